seg7_multi_digit_driver: RTL and testbench



---
 rtl/seg7_multi_digit_driver.sv | 191 +++++++++++++++++++
 tb/tb_seg7_multi_digit_driver.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_digit_driver.sv
// Multi-digit seven-segment driver: hex or sequential double-dabble decimal,
// with leading-zero blanking and overflow dashes.
module seg7_multi_digit_driver #(
    parameter int WIDTH      = 16,
    parameter int NUM_DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_value,
    input  logic                    in_hex,
    input  logic                    blank_lz,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    out_valid,
    output logic                    overflow
);
    localparam int BW = 4 * NUM_DIGITS;
    localparam int PW = (WIDTH > BW) ? WIDTH : BW;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH out of range 1..32");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS out of range 1..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0]        bin;
    logic [BW-1:0]           bcd;
    logic [CW-1:0]           cnt;
    logic                    hex_mode;
    logic                    blank_mode;
    logic                    dec_ovf;
    logic                    latched;
    logic [7*NUM_DIGITS-1:0] seg_pend;
    logic                    ovf_pend;
    logic                    take;

    assign in_ready = (state == IDLE);
    assign take     = in_valid && in_ready;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        unique case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // One double-dabble iteration: add-3 correction then shift {bcd, bin} left.
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_sh;
    logic [WIDTH-1:0] bin_sh;
    logic             shout;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        {shout, bcd_sh, bin_sh} = {bcd_adj, bin, 1'b0};
    end

    logic [PW-1:0] padded;
    logic          hex_ovf;
    logic [BW-1:0] digits;
    logic          ovf_now;

    always_comb begin
        padded  = PW'(bin);
        hex_ovf = |(padded >> BW);
        digits  = hex_mode ? padded[BW-1:0] : bcd;
        ovf_now = hex_mode ? hex_ovf : dec_ovf;
    end

    // Scan from the top digit down; 'lit' goes high at the first nonzero digit.
    logic                    lit;
    logic [7*NUM_DIGITS-1:0] seg_calc;

    always_comb begin
        seg_calc = '1;
        lit      = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lit = lit | (digits[4*i +: 4] != 4'd0) | (i == 0);
            if (ovf_now)
                seg_calc[7*i +: 7] = SEG_DASH;
            else if (blank_mode && !lit)
                seg_calc[7*i +: 7] = SEG_BLANK;
            else
                seg_calc[7*i +: 7] = enc(digits[4*i +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (take) state_next = in_hex ? UPDATE : CONVERT;
            CONVERT: if (cnt == CW'(1)) state_next = UPDATE;
            UPDATE:  if (latched) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // UPDATE spends one cycle registering the decoded digits, then publishes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            hex_mode   <= 1'b0;
            blank_mode <= 1'b0;
            dec_ovf    <= 1'b0;
            latched    <= 1'b0;
            seg_pend   <= '1;
            ovf_pend   <= 1'b0;
            seg_out    <= '1;
            overflow   <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (take) begin
                        bin        <= in_value;
                        hex_mode   <= in_hex;
                        blank_mode <= blank_lz;
                        bcd        <= '0;
                        cnt        <= CW'(WIDTH);
                        dec_ovf    <= 1'b0;
                        latched    <= 1'b0;
                    end
                end
                CONVERT: begin
                    bcd     <= bcd_sh;
                    bin     <= bin_sh;
                    cnt     <= cnt - CW'(1);
                    dec_ovf <= dec_ovf | shout;
                end
                UPDATE: begin
                    if (!latched) begin
                        seg_pend <= seg_calc;
                        ovf_pend <= ovf_now;
                        latched  <= 1'b1;
                    end else begin
                        seg_out   <= seg_pend;
                        overflow  <= ovf_pend;
                        out_valid <= 1'b1;
                        latched   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_multi_digit_driver.sv
// Directed bench for seg7_multi_digit_driver: a 5-digit and a 4-digit
// instance share stimulus and are checked against hand-computed patterns.
module tb_seg7_multi_digit_driver;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_value;
    logic        in_hex;
    logic        blank_lz;
    logic        rdy5, rdy4;
    logic [34:0] seg5;
    logic [27:0] seg4;
    logic        ov5, ov4;
    logic        vld5, vld4;

    int nvec = 0;
    int nerr = 0;

    seg7_multi_digit_driver #(.WIDTH(16), .NUM_DIGITS(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy5),
        .in_value(in_value), .in_hex(in_hex), .blank_lz(blank_lz),
        .seg_out(seg5), .out_valid(vld5), .overflow(ov5)
    );

    seg7_multi_digit_driver #(.WIDTH(16), .NUM_DIGITS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy4),
        .in_value(in_value), .in_hex(in_hex), .blank_lz(blank_lz),
        .seg_out(seg4), .out_valid(vld4), .overflow(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one value, then report update latency and cycles with in_ready low.
    task automatic xfer(input logic [15:0] v, input logic h, input logic b,
                        output int lat, output int busy);
        @(negedge clk);
        in_value = v;
        in_hex   = h;
        blank_lz = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat  = -1;
        busy = rdy5 ? 0 : 1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (vld5) begin
                lat = n;
                break;
            end
            if (!rdy5) busy++;
        end
    endtask

    task automatic test_reset;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_value = '0;
        in_hex   = 1'b0;
        blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        nvec++;
        if (seg5 !== {35{1'b1}}) begin
            nerr++; $display("FAIL reset_seg5 got %h want %h", seg5, {35{1'b1}});
        end
        nvec++;
        if (seg4 !== {28{1'b1}}) begin
            nerr++; $display("FAIL reset_seg4 got %h want %h", seg4, {28{1'b1}});
        end
        nvec++;
        if ({rdy5, vld5, ov5} !== 3'b100) begin
            nerr++; $display("FAIL reset_flags got %b want 100", {rdy5, vld5, ov5});
        end
    endtask

    task automatic test_hex;
        int lat, busy;
        xfer(16'hBEEF, 1'b1, 1'b1, lat, busy);
        nvec++;
        if (lat !== 2) begin
            nerr++; $display("FAIL hex_latency got %0d want 2", lat);
        end
        nvec++;
        if (seg5 !== {BL, SB, SE, SE, SF}) begin
            nerr++; $display("FAIL hex_beef_seg5 got %h want %h", seg5, {BL, SB, SE, SE, SF});
        end
        nvec++;
        if (seg4 !== {SB, SE, SE, SF} || ov4 !== 1'b0 || ov5 !== 1'b0) begin
            nerr++; $display("FAIL hex_beef_seg4 got %h/%b want %h/0", seg4, ov4, {SB, SE, SE, SF});
        end
        @(negedge clk);
        nvec++;
        if (vld5 !== 1'b0) begin
            nerr++; $display("FAIL out_valid_width got %b want 0", vld5);
        end
        xfer(16'h00A5, 1'b1, 1'b0, lat, busy);
        nvec++;
        if (seg5 !== {S0, S0, S0, SA, S5}) begin
            nerr++; $display("FAIL hex_a5_nolz got %h want %h", seg5, {S0, S0, S0, SA, S5});
        end
    endtask

    task automatic test_dec_max;
        int lat, busy;
        xfer(16'd65535, 1'b0, 1'b0, lat, busy);
        nvec++;
        if (lat !== 18) begin
            nerr++; $display("FAIL dec_latency got %0d want 18", lat);
        end
        nvec++;
        if (busy !== 18) begin
            nerr++; $display("FAIL dec_busy_cycles got %0d want 18", busy);
        end
        nvec++;
        if (seg5 !== {S6, S5, S5, S3, S5} || ov5 !== 1'b0) begin
            nerr++; $display("FAIL dec_65535_seg5 got %h/%b want %h/0", seg5, ov5, {S6, S5, S5, S3, S5});
        end
        nvec++;
        if (seg4 !== {DS, DS, DS, DS} || ov4 !== 1'b1) begin
            nerr++; $display("FAIL dec_65535_ovf4 got %h/%b want %h/1", seg4, ov4, {DS, DS, DS, DS});
        end
    endtask

    task automatic test_overflow;
        int lat, busy;
        xfer(16'd12345, 1'b0, 1'b1, lat, busy);
        nvec++;
        if (seg4 !== {DS, DS, DS, DS} || ov4 !== 1'b1) begin
            nerr++; $display("FAIL ovf_12345_seg4 got %h/%b want %h/1", seg4, ov4, {DS, DS, DS, DS});
        end
        nvec++;
        if (seg5 !== {S1, S2, S3, S4, S5} || ov5 !== 1'b0) begin
            nerr++; $display("FAIL dec_12345_seg5 got %h/%b want %h/0", seg5, ov5, {S1, S2, S3, S4, S5});
        end
        xfer(16'd42, 1'b0, 1'b1, lat, busy);
        nvec++;
        if (seg4 !== {BL, BL, S4, S2} || ov4 !== 1'b0) begin
            nerr++; $display("FAIL ovf_clear_42 got %h/%b want %h/0", seg4, ov4, {BL, BL, S4, S2});
        end
        nvec++;
        if (seg5 !== {BL, BL, BL, S4, S2}) begin
            nerr++; $display("FAIL dec_42_seg5 got %h want %h", seg5, {BL, BL, BL, S4, S2});
        end
    endtask

    task automatic test_zero;
        int lat, busy;
        xfer(16'd0, 1'b0, 1'b1, lat, busy);
        nvec++;
        if (seg5 !== {BL, BL, BL, BL, S0} || seg4 !== {BL, BL, BL, S0}) begin
            nerr++; $display("FAIL zero_dec got %h/%h want %h/%h", seg5, seg4,
                             {BL, BL, BL, BL, S0}, {BL, BL, BL, S0});
        end
        xfer(16'd5, 1'b1, 1'b0, lat, busy);
        xfer(16'd0, 1'b1, 1'b1, lat, busy);
        nvec++;
        if (seg5 !== {BL, BL, BL, BL, S0} || seg4 !== {BL, BL, BL, S0}) begin
            nerr++; $display("FAIL zero_hex got %h/%h want %h/%h", seg5, seg4,
                             {BL, BL, BL, BL, S0}, {BL, BL, BL, S0});
        end
    endtask

    task automatic test_busy;
        int pulses, first_at, second_at;
        @(negedge clk);
        in_value = 16'd100;
        in_hex   = 1'b0;
        blank_lz = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_value  = 16'd7;
        pulses    = 0;
        first_at  = -1;
        second_at = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (vld5) begin
                pulses++;
                if (first_at < 0) first_at = n;
                else if (second_at < 0) second_at = n;
            end
            if (first_at < 0) begin
                in_hex = ~in_hex;
            end else if (n == first_at) begin
                nvec++;
                if (seg5 !== {BL, BL, S1, S0, S0} || rdy5 !== 1'b1) begin
                    nerr++; $display("FAIL busy_100_seg got %h/%b want %h/1", seg5, rdy5, {BL, BL, S1, S0, S0});
                end
                in_hex = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        nvec++;
        if (first_at !== 18) begin
            nerr++; $display("FAIL busy_first_latency got %0d want 18", first_at);
        end
        nvec++;
        if (second_at !== 21) begin
            nerr++; $display("FAIL busy_second_at got %0d want 21", second_at);
        end
        nvec++;
        if (pulses !== 2) begin
            nerr++; $display("FAIL busy_pulse_count got %0d want 2", pulses);
        end
        nvec++;
        if (seg5 !== {BL, BL, BL, BL, S7}) begin
            nerr++; $display("FAIL busy_7_seg got %h want %h", seg5, {BL, BL, BL, BL, S7});
        end
    endtask

    task automatic test_reset_mid;
        int lat, busy, pulses;
        xfer(16'd65535, 1'b0, 1'b0, lat, busy);
        @(negedge clk);
        in_value = 16'd321;
        in_hex   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        nvec++;
        if (seg5 !== {35{1'b1}} || seg4 !== {28{1'b1}}) begin
            nerr++; $display("FAIL midreset_seg got %h/%h want all ones", seg5, seg4);
        end
        nvec++;
        if ({rdy5, vld5, ov5, rdy4, ov4} !== 5'b10010) begin
            nerr++; $display("FAIL midreset_flags got %b want 10010", {rdy5, vld5, ov5, rdy4, ov4});
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses  = 0;
        repeat (25) begin
            @(negedge clk);
            if (vld5 || vld4) pulses++;
        end
        nvec++;
        if (pulses !== 0 || seg5 !== {35{1'b1}}) begin
            nerr++; $display("FAIL midreset_abort got %0d pulses seg %h want 0 and all ones", pulses, seg5);
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_dec_max();
        test_overflow();
        test_zero();
        test_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
